fir_decim_buf: RTL and testbench
================================

# fir_decim_buf

Downstream stage of the `fir` filter. Takes the filter's signed sample stream, decimates it by a fixed power-of-two factor, and queues the decimated samples in a small FIFO. The FIFO drains through a valid/ready handshake, so the consumer can stall without back-pressuring the free-running FIR. Drops caused by a full FIFO are flagged by a sticky overflow bit.

## Interface
- `WORD_SIZE`, 8: sample width, signed two's complement; matches `fir`.
- `DECIM`, 4: decimation factor; power of two, 2..16.
- `FIFO_DEPTH`, 4: FIFO entries; power of two, 2..16.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `filter_out`  in  WORD_SIZE  signed sample from `fir`.
- `in_en`  in  1  sample on `filter_out` is accepted at this edge.
- `dec_out`  out  WORD_SIZE  signed FIFO head sample.
- `dec_valid`  out  1  FIFO non-empty; `dec_out` is valid.
- `dec_ready`  in  1  consumer accepts head when `dec_valid` is high.
- `fifo_cnt`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `ovf`  out  1  sticky; a decimated sample was dropped.

## Operation
- Phase counter runs 0..DECIM-1.
  - Advances only on edges with `in_en` = 1.
  - Wraps to 0 after DECIM-1.
- Group complete: an accepted sample arrives while phase = DECIM-1. That edge creates one decimated sample and issues a push request.
- Decimated value, pick mode (default): the sample accepted at phase DECIM-1.
- FIFO: circular buffer with read/write pointers and a count.
  - Pop at an edge when `dec_valid` && `dec_ready`.
  - Push at an edge when a push request is pending and the FIFO is not full, or is full with a pop at the same edge.
  - Full, push request, no pop: the new sample is dropped and `ovf` is set to 1. The FIFO contents are unchanged.
  - Empty with a push request: no fall-through. The sample becomes visible the next cycle.
- `dec_out` is the head entry. It holds stable while `dec_valid` && !`dec_ready`.
- `ovf` is cleared only by `rst`.
- Reset values:
  - phase 0, accumulator 0, pointers 0
  - `fifo_cnt` 0, `dec_valid` 0, `dec_out` 0, `ovf` 0
- Reset mid-group discards the partial group. Reset overrides a simultaneous push or pop.
- `in_en` = 0 freezes the phase and accumulator; the FIFO still drains.

## Timing
- Latency: a group completing at edge k gives `dec_valid` = 1 and `dec_out` = value in the cycle after edge k, provided the FIFO was empty.
- Throughput: at most one push per DECIM accepted samples. Pop rate is up to one per cycle.
- `fifo_cnt` and `dec_valid` are registered and update at the same edge as the push or pop.
- Simultaneous push and pop, any occupancy (including full): count unchanged, both operations succeed, `ovf` unaffected.
- Simultaneous push and pop with count = 1: the head advances to the new sample and `dec_valid` stays 1.
- No combinational path from `dec_ready` to `dec_valid`. `dec_out` may be a mux from the FIFO storage.

## Configuration
- `DECIM_AVG_EN` defined: boxcar averaging replaces pick mode.
  - Accumulator width: WORD_SIZE+$clog2(DECIM), signed.
  - At phase 0 the accumulator loads the sample; other phases add the sample to it.
  - Decimated value = (accumulator + final sample) >>> $clog2(DECIM). This is an arithmetic shift, so results floor toward −∞. No saturation is needed: the result always fits in WORD_SIZE.
- `DECIM_AVG_EN` undefined: pick mode only. No accumulator is synthesised.

## Test plan
- Pick mode, DECIM=4. `in_en`=1 and `dec_ready`=1 throughout; inputs 0,10,…,70 → `dec_out` 30 one cycle after 30 is accepted, then 70 one cycle after 70. `dec_valid` pulses one cycle each, `fifo_cnt` peaks at 1.
- `DECIM_AVG_EN`, DECIM=4:
  - Inputs 0,10,…,70 → outputs 15, then 55.
  - Inputs −1,−2,−3,−4 → output −3 (floor of −2.5).
- Overflow, FIFO_DEPTH=4, `dec_ready`=0, pick mode: inputs 0..19 → FIFO holds 3,7,11,15; sample 19 is dropped.
  - Result: `fifo_cnt`=4, `ovf`=1.
  - Then `dec_ready`=1: 3,7,11,15 pop on consecutive cycles, `dec_valid` falls, and `ovf` stays 1.
- Simultaneous push and pop at full: FIFO full, `dec_ready`=1 on the edge a group completes → `fifo_cnt` stays 4, `ovf` stays 0, and the new value is at the tail.
- Reset mid-group: accept 5,6, then `rst` for one cycle, then accept 100,101,102,103 → single output 103 (pick mode), with `dec_valid` 0 throughout the reset cycle.
- Stall: with one entry queued, hold `dec_ready`=0 for 5 cycles while `in_en`=0 → `dec_out` and `dec_valid` are unchanged each cycle.

Source files
------------

// File: rtl/fir_decim_buf.sv
// fir_decim_buf: decimates the signed FIR sample stream by DECIM and queues
// the decimated samples in a FIFO_DEPTH-entry FIFO drained by valid/ready.
// A push into a full FIFO without a simultaneous pop drops the sample and
// sets the sticky ovf flag.
// Optional feature: define DECIM_AVG_EN to replace pick mode (last sample of
// each group) with a boxcar average of the DECIM samples of the group.
module fir_decim_buf #(
   parameter int WORD_SIZE  = 8,
   parameter int DECIM      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic signed [WORD_SIZE-1:0]   filter_out,
   input  logic                          in_en,
   output logic signed [WORD_SIZE-1:0]   dec_out,
   output logic                          dec_valid,
   input  logic                          dec_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
   output logic                          ovf
);

   localparam int PH_W  = $clog2(DECIM);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PH_W-1:0]               phase_q, phase_d;
   logic                          group_done;
   logic signed [WORD_SIZE-1:0]   push_data;
   logic                          push, pop, full;
   logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic                          valid_q, valid_d;
   logic                          ovf_q, ovf_d;
   logic signed [WORD_SIZE-1:0]   mem_q [FIFO_DEPTH];

   // Phase counter advances on accepted samples; DECIM is a power of two so it wraps naturally
   always_comb begin
      phase_d    = phase_q;
      group_done = in_en && (phase_q == PH_W'(DECIM - 1));
      if (in_en) phase_d = phase_q + PH_W'(1);
   end

   // Phase register
   always_ff @(posedge clk) begin
      if (rst) phase_q <= '0;
      else     phase_q <= phase_d;
   end

`ifdef DECIM_AVG_EN
   localparam int ACC_W = WORD_SIZE + PH_W;

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] sample_ext;

   // Divide the group sum by DECIM; arithmetic shift floors toward -inf and
   // the mean of DECIM in-range samples always fits back into WORD_SIZE
   function automatic logic signed [WORD_SIZE-1:0] avg_scale(
      input logic signed [ACC_W-1:0] sum
   );
      return WORD_SIZE'(sum >>> PH_W);
   endfunction

   // Boxcar accumulator: phase 0 restarts the sum, later phases add to it
   always_comb begin
      sample_ext = ACC_W'(filter_out);
      acc_d      = acc_q;
      if (in_en) begin
         if (phase_q == '0) acc_d = sample_ext;
         else               acc_d = acc_q + sample_ext;
      end
      push_data = avg_scale(acc_q + sample_ext);
   end

   // Accumulator register
   always_ff @(posedge clk) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
   end
`else
   // Pick mode: the decimated value is the sample closing the group
   always_comb begin
      push_data = filter_out;
   end
`endif

   // FIFO control: pop frees a slot in the same edge, so a full FIFO can still accept a push
   always_comb begin
      full     = (cnt_q == CNT_W'(FIFO_DEPTH));
      pop      = valid_q && dec_ready;
      push     = group_done && (!full || pop);
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      cnt_d    = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
      valid_d  = (cnt_d != '0);
      ovf_d    = ovf_q | (group_done && full && !pop);
   end

   // FIFO control registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
      end
   end

   // FIFO storage; data is not reset, empty entries are masked at the output
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end

   // Outputs: head entry, forced to zero while the FIFO is empty
   always_comb begin
      dec_out   = valid_q ? mem_q[rd_ptr_q] : '0;
      dec_valid = valid_q;
      fifo_cnt  = cnt_q;
      ovf       = ovf_q;
   end

endmodule

// File: tb/tb_fir_decim_buf.sv
// Directed bench for fir_decim_buf with default parameters (WORD_SIZE=8,
// DECIM=4, FIFO_DEPTH=4). Pick-mode scenarios run in the default build;
// the averaging scenario runs when DECIM_AVG_EN is defined.
module tb_fir_decim_buf;

   logic              clk = 1'b0;
   logic              rst;
   logic signed [7:0] filter_out;
   logic              in_en;
   logic signed [7:0] dec_out;
   logic              dec_valid;
   logic              dec_ready;
   logic [2:0]        fifo_cnt;
   logic              ovf;

   int total = 0;
   int bad   = 0;

   fir_decim_buf #(.WORD_SIZE(8), .DECIM(4), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .filter_out (filter_out),
      .in_en      (in_en),
      .dec_out    (dec_out),
      .dec_valid  (dec_valid),
      .dec_ready  (dec_ready),
      .fifo_cnt   (fifo_cnt),
      .ovf        (ovf)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_en = 1'b0; dec_ready = 1'b0; filter_out = '0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_en = 1'b1; dec_ready = 1'b1; filter_out = 8'sd55;
      step();
      step();
      total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0d want=0", dec_valid); end
      total++; if (dec_out !== 8'sd0) begin bad++; $display("FAIL reset_out got=%0d want=0", dec_out); end
      total++; if (fifo_cnt !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", fifo_cnt); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0d want=0", ovf); end
      rst = 1'b0; in_en = 1'b0; dec_ready = 1'b0;
   endtask

   task automatic test_pick();
      logic signed [7:0] exp_v;
      do_reset();
      in_en = 1'b1; dec_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         filter_out = 8'(10 * i);
         step();
         exp_v = 8'(10 * i);
         if (i == 3 || i == 7) begin
            total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL pick_valid i=%0d got=%0d want=1", i, dec_valid); end
            total++; if (dec_out !== exp_v) begin bad++; $display("FAIL pick_out i=%0d got=%0d want=%0d", i, dec_out, exp_v); end
            total++; if (fifo_cnt !== 3'd1) begin bad++; $display("FAIL pick_cnt i=%0d got=%0d want=1", i, fifo_cnt); end
         end else begin
            total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL pick_idle i=%0d got=%0d want=0", i, dec_valid); end
            total++; if (fifo_cnt !== 3'd0) begin bad++; $display("FAIL pick_cnt0 i=%0d got=%0d want=0", i, fifo_cnt); end
         end
      end
      in_en = 1'b0;
   endtask

   task automatic test_overflow();
      logic signed [7:0] exp_v;
      do_reset();
      in_en = 1'b1; dec_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         filter_out = 8'(i);
         step();
         if (i == 15) begin
            total++; if (fifo_cnt !== 3'd4) begin bad++; $display("FAIL ovf_fill_cnt got=%0d want=4", fifo_cnt); end
            total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0d want=0", ovf); end
         end
      end
      total++; if (fifo_cnt !== 3'd4) begin bad++; $display("FAIL ovf_cnt got=%0d want=4", fifo_cnt); end
      total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0d want=1", ovf); end
      in_en = 1'b0; dec_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_v = 8'(3 + 4 * k);
         total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL ovf_drain_valid k=%0d got=%0d want=1", k, dec_valid); end
         total++; if (dec_out !== exp_v) begin bad++; $display("FAIL ovf_drain_out k=%0d got=%0d want=%0d", k, dec_out, exp_v); end
         step();
      end
      total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%0d want=0", dec_valid); end
      total++; if (fifo_cnt !== 3'd0) begin bad++; $display("FAIL ovf_empty_cnt got=%0d want=0", fifo_cnt); end
      total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0d want=1", ovf); end
      dec_ready = 1'b0;
   endtask

   task automatic test_simul_full();
      logic signed [7:0] exp_v;
      do_reset();
      in_en = 1'b1; dec_ready = 1'b0;
      for (int i = 1; i <= 19; i++) begin
         filter_out = 8'(i);
         step();
      end
      total++; if (fifo_cnt !== 3'd4) begin bad++; $display("FAIL simul_pre_cnt got=%0d want=4", fifo_cnt); end
      filter_out = 8'sd20; dec_ready = 1'b1;
      step();
      total++; if (fifo_cnt !== 3'd4) begin bad++; $display("FAIL simul_cnt got=%0d want=4", fifo_cnt); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL simul_ovf got=%0d want=0", ovf); end
      in_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp_v = 8'(8 + 4 * k);
         total++; if (dec_out !== exp_v) begin bad++; $display("FAIL simul_drain k=%0d got=%0d want=%0d", k, dec_out, exp_v); end
         step();
      end
      total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL simul_empty got=%0d want=0", dec_valid); end
      dec_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      in_en = 1'b1; dec_ready = 1'b1;
      filter_out = 8'sd5; step();
      filter_out = 8'sd6; step();
      rst = 1'b1; filter_out = 8'sd7;
      step();
      total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL rmid_rst_valid got=%0d want=0", dec_valid); end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         filter_out = 8'(100 + i);
         step();
         if (i < 3) begin
            total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL rmid_early i=%0d got=%0d want=0", i, dec_valid); end
         end else begin
            total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL rmid_valid got=%0d want=1", dec_valid); end
            total++; if (dec_out !== 8'sd103) begin bad++; $display("FAIL rmid_out got=%0d want=103", dec_out); end
         end
      end
      in_en = 1'b0;
      step();
      total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL rmid_single got=%0d want=0", dec_valid); end
   endtask

   task automatic test_stall();
      do_reset();
      in_en = 1'b1; dec_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         filter_out = 8'(40 + i);
         step();
      end
      in_en = 1'b0; filter_out = 8'sd99;
      for (int c = 0; c < 5; c++) begin
         step();
         total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL stall_valid c=%0d got=%0d want=1", c, dec_valid); end
         total++; if (dec_out !== 8'sd43) begin bad++; $display("FAIL stall_out c=%0d got=%0d want=43", c, dec_out); end
         total++; if (fifo_cnt !== 3'd1) begin bad++; $display("FAIL stall_cnt c=%0d got=%0d want=1", c, fifo_cnt); end
      end
      dec_ready = 1'b1;
      step();
      total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL stall_pop got=%0d want=0", dec_valid); end
      dec_ready = 1'b0;
   endtask

`ifdef DECIM_AVG_EN
   task automatic test_avg();
      logic signed [7:0] exp_v;
      do_reset();
      in_en = 1'b1; dec_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         filter_out = 8'(10 * i);
         step();
         if (i == 3 || i == 7) begin
            exp_v = (i == 3) ? 8'sd15 : 8'sd55;
            total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL avg_valid i=%0d got=%0d want=1", i, dec_valid); end
            total++; if (dec_out !== exp_v) begin bad++; $display("FAIL avg_out i=%0d got=%0d want=%0d", i, dec_out, exp_v); end
         end
      end
      for (int i = 1; i <= 4; i++) begin
         filter_out = 8'(-i);
         step();
      end
      exp_v = -8'sd3;
      total++; if (dec_out !== exp_v) begin bad++; $display("FAIL avg_neg got=%0d want=%0d", dec_out, exp_v); end
      in_en = 1'b0;
   endtask
`endif

   initial begin
      rst = 1'b1; in_en = 1'b0; dec_ready = 1'b0; filter_out = '0;
      test_reset();
`ifdef DECIM_AVG_EN
      test_avg();
`else
      test_pick();
      test_overflow();
      test_simul_full();
      test_reset_mid();
      test_stall();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
